alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
// Shares one combinational ALU instance among NREQ requesters (e.g. PC-increment, branch-compare, execute in the multicycle CPU).
// Round-robin arbitration, registered operands to the ALU, registered result back to the granted requester.
// One operation in flight at a time. Requester and response sides use valid/ready handshakes.
// PARAMETERS
// NREQ   2   number of requesters (2..8)
// PORTS
// clk         in   1         system clock, all state updates on rising edge
// rst_n       in   1         synchronous reset, active-low
// req_valid   in   NREQ      requester i has an operation pending
// req_ready   out  NREQ      one-hot; request i accepted this cycle (valid&ready)
// req_a       in   NREQ*32   operand A of requester i at bits [32*i+31:32*i]
// req_b       in   NREQ*32   operand B of requester i
// req_ctr     in   NREQ*4    4-bit ALU control of requester i, ALUctr encoding
// rsp_valid   out  NREQ      one-hot; result for requester i is presented
// rsp_ready   in   NREQ      requester i consumes result
// rsp_result  out  32        result of the completed operation
// rsp_less    out  1         less flag (0 unless op is slt/sltu)
// rsp_zero    out  1         zero flag as produced by the ALU
// alu_dataa   out  32        to ALU dataa
// alu_datab   out  32        to ALU datab
// alu_ctr     out  4         to ALU ALUctr
// alu_result  in   32        from ALU aluresult
// alu_less    in   1         from ALU less
// alu_zero    in   1         from ALU zero
// busy        out  1         high in EXEC or RESP
// BEHAVIOUR
// - Reset (rst_n=0 at edge): state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_result=0, rsp_less=0, rsp_zero=0,
//   alu_dataa=0, alu_datab=0, alu_ctr=0 (add), busy=0. Reset mid-operation drops the operation; no response issued.
// - FSM states IDLE, EXEC, RESP.
// - IDLE: req_ready is combinational: one-hot grant to first i with req_valid[i] searching from rr_ptr upward, wrapping.
//   On grant: latch req_a/req_b/req_ctr of i into alu_* regs, latch owner=i, rr_ptr <= (i+1) mod NREQ, -> EXEC.
//   No req_valid: stay IDLE, req_ready=0.
// - EXEC (exactly 1 cycle): ALU settles on registered operands; capture alu_result/alu_zero into rsp_* regs;
//   rsp_less <= alu_less if alu_ctr[2:0]==3'b010, else 0 (ALU less undefined for other ops). -> RESP.
// - RESP: rsp_valid[owner]=1, outputs held stable until rsp_ready[owner]=1; then -> IDLE. rsp_ready of other bits ignored.
// - req_ready=0 in EXEC and RESP; a new grant cannot occur in the same cycle as a response handshake.
// - Latency: accept at cycle T, rsp_valid at T+2 (best case); throughput 1 op per 3 cycles.
// - alu_* outputs hold last operation's values while IDLE (no toggling).
// - Requests must hold req_a/b/ctr stable only while req_valid=1 and not yet accepted.
// - Fairness: a continuously requesting requester is granted within NREQ grants.
// - rr_ptr wraps NREQ-1 -> 0; non-power-of-two NREQ must wrap correctly (no out-of-range index).
// - All 16 ALUctr codes passed through unchanged; arbiter does not decode except for the less mask.
// TESTING
// 1 Reset: rst_n=0 2 cycles with all req_valid=1 -> all outputs 0, no req_ready; release -> grant req0 first cycle.
// 2 Single op: req1 a=5 b=7 ctr=4'b1000 (sub) -> rsp_valid=2'b10 two cycles later, result=32'hFFFFFFFE, zero=0, less=0.
// 3 slt signed: a=32'hFFFFFFFF b=1 ctr=4'b0010 -> result=1, less=1; sltu same operands ctr=4'b1010 -> result=0, less=0.
// 4 Contention NREQ=3, all valid continuously -> grant order 0,1,2,0,1; each response matches its own operands.
// 5 Backpressure: hold rsp_ready=0 10 cycles -> rsp_valid/result stable, req_ready=0 throughout; then ready -> IDLE next.
// 6 Reset in EXEC and in RESP -> no rsp_valid after reset, rr_ptr=0, next grant follows reset ordering.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one external combinational ALU among NREQ requesters.
// One operation in flight: IDLE grants, EXEC captures the ALU outputs, RESP holds the result until it is consumed.
module alu_share_arbiter #(
  parameter int NREQ = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*32-1:0]   req_a,
  input  logic [NREQ*32-1:0]   req_b,
  input  logic [NREQ*4-1:0]    req_ctr,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [31:0]          rsp_result,
  output logic                 rsp_less,
  output logic                 rsp_zero,
  output logic [31:0]          alu_dataa,
  output logic [31:0]          alu_datab,
  output logic [3:0]           alu_ctr,
  input  logic [31:0]          alu_result,
  input  logic                 alu_less,
  input  logic                 alu_zero,
  output logic                 busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]    owner_q, owner_d;
  logic [NREQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_result_q, rsp_result_d;
  logic             rsp_less_q, rsp_less_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic [31:0]      alu_dataa_q, alu_dataa_d;
  logic [31:0]      alu_datab_q, alu_datab_d;
  logic [3:0]       alu_ctr_q, alu_ctr_d;
  logic             busy_q, busy_d;
  logic [PW-1:0]    gnt_idx_s;
  logic             gnt_found_s;

  // Scanning from the highest offset down lets the first valid requester at or after rr_ptr_q win.
  always_comb begin
    int idx;
    idx         = 0;
    gnt_idx_s   = '0;
    gnt_found_s = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx         = int'(rr_ptr_q) + k;
      idx         = (idx >= NREQ) ? (idx - NREQ) : idx;
      gnt_idx_s   = req_valid[idx] ? PW'(idx) : gnt_idx_s;
      gnt_found_s = gnt_found_s | req_valid[idx];
    end
  end

  // Next state, grant, operand latch and result capture.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_less_d   = rsp_less_q;
    rsp_zero_d   = rsp_zero_q;
    alu_dataa_d  = alu_dataa_q;
    alu_datab_d  = alu_datab_q;
    alu_ctr_d    = alu_ctr_q;
    busy_d       = busy_q;
    req_ready    = '0;
    case (state_q)
      IDLE: begin
        // Grant is suppressed while reset is asserted so no requester sees a false acceptance.
        if (gnt_found_s && rst_n) begin
          req_ready[gnt_idx_s] = 1'b1;
          alu_dataa_d = req_a[{gnt_idx_s, 5'b00000} +: 32];
          alu_datab_d = req_b[{gnt_idx_s, 5'b00000} +: 32];
          alu_ctr_d   = req_ctr[{gnt_idx_s, 2'b00} +: 4];
          owner_d     = gnt_idx_s;
          rr_ptr_d    = (gnt_idx_s == PW'(NREQ - 1)) ? '0 : (gnt_idx_s + 1'b1);
          busy_d      = 1'b1;
          state_d     = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        rsp_result_d         = alu_result;
        rsp_zero_d           = alu_zero;
        // The ALU less output is only meaningful for slt/sltu.
        rsp_less_d           = (alu_ctr_q[2:0] == 3'b010) ? alu_less : 1'b0;
        rsp_valid_d          = '0;
        rsp_valid_d[owner_q] = 1'b1;
        state_d              = RESP;
      end
      RESP: begin
        if (rsp_ready[owner_q]) begin
          rsp_valid_d = '0;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        rsp_valid_d = '0;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      rsp_valid_q  <= '0;
      rsp_result_q <= 32'd0;
      rsp_less_q   <= 1'b0;
      rsp_zero_q   <= 1'b0;
      alu_dataa_q  <= 32'd0;
      alu_datab_q  <= 32'd0;
      alu_ctr_q    <= 4'd0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_less_q   <= rsp_less_d;
      rsp_zero_q   <= rsp_zero_d;
      alu_dataa_q  <= alu_dataa_d;
      alu_datab_q  <= alu_datab_d;
      alu_ctr_q    <= alu_ctr_d;
      busy_q       <= busy_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_less   = rsp_less_q;
  assign rsp_zero   = rsp_zero_q;
  assign alu_dataa  = alu_dataa_q;
  assign alu_datab  = alu_datab_q;
  assign alu_ctr    = alu_ctr_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter with three requesters and a behavioural ALU.
// Grants and responses are predicted from the arbitration rules; a monitor process checks every cycle.
module tb_alu_share_arbiter;

  localparam int NREQ = 3;

  logic                clk;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*32-1:0]  req_a;
  logic [NREQ*32-1:0]  req_b;
  logic [NREQ*4-1:0]   req_ctr;
  logic [NREQ-1:0]     rsp_valid;
  logic [NREQ-1:0]     rsp_ready;
  logic [31:0]         rsp_result;
  logic                rsp_less;
  logic                rsp_zero;
  logic [31:0]         alu_dataa;
  logic [31:0]         alu_datab;
  logic [3:0]          alu_ctr;
  logic [31:0]         alu_result;
  logic                alu_less;
  logic                alu_zero;
  logic                busy;

  alu_share_arbiter #(.NREQ(NREQ)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_ctr(req_ctr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_less(rsp_less), .rsp_zero(rsp_zero),
    .alu_dataa(alu_dataa), .alu_datab(alu_datab), .alu_ctr(alu_ctr),
    .alu_result(alu_result), .alu_less(alu_less), .alu_zero(alu_zero),
    .busy(busy)
  );

  typedef struct {
    int          owner;
    logic [31:0] res;
    logic        less;
    logic        zero;
    int          acc;
  } exp_t;

  exp_t            sb_q[$];
  int              gnt_log[$];
  int              model_ptr = 0;
  int              cyc = 0;
  int              errors = 0;
  int              checks = 0;
  logic [NREQ-1:0] acc_flag = '0;

  // Behavioural ALU: returns {less, zero, result}; less is junk for non-slt ops.
  function automatic logic [33:0] alu_f(logic [31:0] a, logic [31:0] b, logic [3:0] c);
    logic [31:0] r;
    logic        lt;
    lt = c[3] ? (a < b) : ($signed(a) < $signed(b));
    case (c[2:0])
      3'b000:  r = c[3] ? a - b : a + b;
      3'b001:  r = a << b[4:0];
      3'b010:  r = {31'd0, lt};
      3'b011:  r = b;
      3'b100:  r = a ^ b;
      3'b101:  r = c[3] ? ($signed(a) >>> b[4:0]) : (a >> b[4:0]);
      3'b110:  r = a | b;
      default: r = a & b;
    endcase
    return {(c[2:0] == 3'b010) ? lt : (a[0] ^ b[1] ^ c[3]), (r == 32'd0), r};
  endfunction

  always_comb begin
    {alu_less, alu_zero, alu_result} = alu_f(alu_dataa, alu_datab, alu_ctr);
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [NREQ-1:0] oh(int i);
    logic [NREQ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_op(int i, logic [31:0] a, logic [31:0] b, logic [3:0] c);
    req_valid[i]        = 1'b1;
    req_a[32*i +: 32]   = a;
    req_b[32*i +: 32]   = b;
    req_ctr[4*i +: 4]   = c;
  endtask

  task automatic new_op(int i);
    logic [31:0] a;
    logic [31:0] b;
    a = $urandom;
    b = ($urandom_range(0, 3) == 0) ? a : $urandom;
    set_op(i, a, b, 4'($urandom_range(0, 15)));
  endtask

  // mode 0: accepted requesters drop valid; 1: accepted requesters re-request; 2: fully random
  task automatic advance(int mode);
    logic r;
    r = rst_n;
    @(negedge clk);
    cyc++;
    if (!r) begin
      sb_q.delete();
      model_ptr = 0;
    end
    for (int i = 0; i < NREQ; i++) begin
      if (acc_flag[i]) begin
        acc_flag[i] = 1'b0;
        if (mode == 1) new_op(i);
        else req_valid[i] = 1'b0;
      end
      if (mode == 2 && !req_valid[i] && $urandom_range(0, 2) == 0) new_op(i);
    end
    if (mode == 2) rsp_ready = NREQ'($urandom);
  endtask

  // Predict the grant from the round-robin rule and record the expected response.
  task automatic check_grant();
    logic [NREQ-1:0] exp_rdy;
    logic [33:0]     r;
    logic [3:0]      c;
    exp_t            e;
    int              g;
    #1;
    exp_rdy = '0;
    g = -1;
    if (rst_n && sb_q.size() == 0) begin
      for (int k = 0; k < NREQ; k++) begin
        int j;
        j = (model_ptr + k) % NREQ;
        if (g < 0 && req_valid[j]) g = j;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", req_ready, exp_rdy);
    if (g >= 0) begin
      c = req_ctr[4*g +: 4];
      r = alu_f(req_a[32*g +: 32], req_b[32*g +: 32], c);
      e.owner = g;
      e.res   = r[31:0];
      e.zero  = r[32];
      e.less  = (c[2:0] == 3'b010) ? r[0] : 1'b0;
      e.acc   = cyc;
      sb_q.push_back(e);
      model_ptr = (g + 1) % NREQ;
      acc_flag[g] = 1'b1;
      gnt_log.push_back(g);
    end
  endtask

  task automatic run(int mode, int n);
    for (int i = 0; i < n; i++) begin
      advance(mode);
      check_grant();
    end
  endtask

  task automatic drain();
    rsp_ready = '1;
    run(0, 12);
  endtask

  task automatic single(int i, logic [31:0] a, logic [31:0] b, logic [3:0] c,
                        logic [31:0] xres, logic xless, logic xzero);
    rsp_ready = '1;
    advance(0);
    set_op(i, a, b, c);
    check_grant();
    advance(0);
    check_grant();
    advance(0);
    check_grant();
    #2;
    chk("dir_rsp_valid", rsp_valid, oh(i));
    chk("dir_result", rsp_result, xres);
    chk("dir_less", rsp_less, xless);
    chk("dir_zero", rsp_zero, xzero);
    run(0, 2);
  endtask

  // Monitor: compares presented responses against the scoreboard head every cycle.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb_q.size() == 0) begin
        chk("rsp_valid_idle", rsp_valid, 64'd0);
        chk("busy_idle", busy, 64'd0);
      end else begin
        e = sb_q[0];
        chk("busy", busy, (cyc >= e.acc + 1));
        if (cyc < e.acc + 2) begin
          chk("rsp_valid_early", rsp_valid, 64'd0);
        end else begin
          chk("rsp_valid", rsp_valid, oh(e.owner));
          chk("rsp_result", rsp_result, e.res);
          chk("rsp_less", rsp_less, e.less);
          chk("rsp_zero", rsp_zero, e.zero);
          if (rsp_ready[e.owner]) begin
            void'(sb_q.pop_front());
          end else if (cyc - e.acc > 100) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout: owner %0d waited %0d cycles", e.owner, cyc - e.acc);
            void'(sb_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_ctr   = '0;
    rsp_ready = '1;
    rst_n     = 1'b0;
    for (int i = 0; i < NREQ; i++) new_op(i);

    // Reset with everything requesting, then release: requester 0 first.
    check_grant();
    advance(0);
    check_grant();
    chk("rst_req_ready", req_ready, 64'd0);
    chk("rst_rsp_valid", rsp_valid, 64'd0);
    chk("rst_result", rsp_result, 64'd0);
    chk("rst_less", rsp_less, 64'd0);
    chk("rst_zero", rsp_zero, 64'd0);
    chk("rst_dataa", alu_dataa, 64'd0);
    chk("rst_datab", alu_datab, 64'd0);
    chk("rst_ctr", alu_ctr, 64'd0);
    chk("rst_busy", busy, 64'd0);
    advance(0);
    rst_n = 1'b1;
    check_grant();
    chk("rst_first_grant", req_ready, 64'd1);
    drain();

    // Directed single operations.
    single(1, 32'd5, 32'd7, 4'b1000, 32'hFFFF_FFFE, 1'b0, 1'b0);
    single(0, 32'hFFFF_FFFF, 32'd1, 4'b0010, 32'd1, 1'b1, 1'b0);
    single(2, 32'hFFFF_FFFF, 32'd1, 4'b1010, 32'd0, 1'b0, 1'b1);

    // Contention after reset: order 0,1,2,0,1.
    advance(0);
    rst_n = 1'b0;
    check_grant();
    advance(0);
    rst_n = 1'b1;
    gnt_log.delete();
    for (int i = 0; i < NREQ; i++) new_op(i);
    rsp_ready = '1;
    check_grant();
    run(1, 15);
    chk("contention_cnt", gnt_log.size() >= 5, 64'd1);
    if (gnt_log.size() >= 5) begin
      chk("order0", gnt_log[0], 64'd0);
      chk("order1", gnt_log[1], 64'd1);
      chk("order2", gnt_log[2], 64'd2);
      chk("order3", gnt_log[3], 64'd0);
      chk("order4", gnt_log[4], 64'd1);
    end
    drain();

    // Backpressure: response held while others wait.
    advance(0);
    rsp_ready = '0;
    new_op(0);
    check_grant();
    advance(0);
    new_op(1);
    new_op(2);
    check_grant();
    run(0, 12);
    rsp_ready = '1;
    run(0, 12);

    // Reset while in EXEC.
    advance(0);
    new_op(0);
    check_grant();
    advance(0);
    rst_n = 1'b0;
    check_grant();
    advance(0);
    rst_n = 1'b1;
    chk("rst_exec_dataa", alu_dataa, 64'd0);
    chk("rst_exec_ctr", alu_ctr, 64'd0);
    new_op(0);
    new_op(2);
    check_grant();
    chk("rst_exec_order", req_ready, 64'd1);
    drain();

    // Reset while in RESP.
    advance(0);
    new_op(1);
    rsp_ready = '0;
    check_grant();
    run(0, 1);
    advance(0);
    rst_n = 1'b0;
    check_grant();
    advance(0);
    rst_n = 1'b1;
    chk("rst_resp_result", rsp_result, 64'd0);
    new_op(0);
    new_op(2);
    check_grant();
    chk("rst_resp_order", req_ready, 64'd1);
    drain();

    // Randomised traffic with random backpressure.
    run(2, 900);
    drain();
    run(0, 4);
    chk("drained", sb_q.size(), 64'd0);

    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
